// File: rtl/hamm_pkg.sv
// rtl/hamm_pkg.sv - shared types, widths and the (7,4) Hamming encode function
package hamm_pkg;

    localparam int CW_W  = 7;
    localparam int NIB_W = 4;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    // Returned vector is code[7:1]; odd parity inverts only the three check bits.
    function automatic logic [CW_W-1:0] hamm_encode(input logic [NIB_W-1:0] nibble,
                                                   input logic parity_type);
        logic p1, p2, p4;
        p1 = nibble[0] ^ nibble[1] ^ nibble[3] ^ parity_type;
        p2 = nibble[0] ^ nibble[2] ^ nibble[3] ^ parity_type;
        p4 = nibble[1] ^ nibble[2] ^ nibble[3] ^ parity_type;
        return {nibble[3], nibble[2], nibble[1], p4, nibble[0], p2, p1};
    endfunction

endpackage

// File: rtl/hamm_nib_enc.sv
// rtl/hamm_nib_enc.sv - combinational single-nibble Hamming encoder
module hamm_nib_enc
    import hamm_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    input  logic             parity_type,
    output logic [CW_W-1:0]  code
);

    assign code = hamm_encode(nibble, parity_type);

endmodule

// File: rtl/hamm_enc_stream.sv
// rtl/hamm_enc_stream.sv - byte stream to two Hamming codewords; HAMM_ENC_ERR_INJ_EN adds error injection
module hamm_enc_stream
    import hamm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             parity_type,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CW_W-1:0]  m_code,
    output logic             m_last,
    output logic [CNT_W-1:0] cw_count
`ifdef HAMM_ENC_ERR_INJ_EN
    ,
    input  logic             err_inj,
    input  logic [2:0]       err_pos
`endif
);

    state_t          state;
    logic [CW_W-1:0] lo_enc, hi_enc, lo_load, hi_code;
    logic            in_xfer, out_xfer;

    hamm_nib_enc u_enc_lo (.nibble(s_data[3:0]), .parity_type(parity_type), .code(lo_enc));
    hamm_nib_enc u_enc_hi (.nibble(s_data[7:4]), .parity_type(parity_type), .code(hi_enc));

`ifdef HAMM_ENC_ERR_INJ_EN
    // err_pos counts codeword positions from 1; position 0 leaves the word clean.
    always_comb begin
        lo_load = lo_enc;
        if (err_inj && err_pos != 3'd0)
            lo_load[err_pos - 3'd1] = ~lo_enc[err_pos - 3'd1];
    end
`else
    assign lo_load = lo_enc;
`endif

    always_comb begin
        s_ready = 1'b0;
        case (state)
            IDLE:    s_ready = 1'b1;
            SEND_HI: s_ready = m_ready;
            default: s_ready = 1'b0;
        endcase
    end

    assign in_xfer  = s_valid && s_ready;
    assign out_xfer = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            m_valid  <= 1'b0;
            m_code   <= '0;
            m_last   <= 1'b0;
            hi_code  <= '0;
            cw_count <= '0;
        end else begin
            if (out_xfer)
                cw_count <= cw_count + 1'b1;
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        m_code  <= lo_load;
                        hi_code <= hi_enc;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        state   <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (m_ready) begin
                        m_code <= hi_code;
                        m_last <= 1'b1;
                        state  <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (m_ready) begin
                        if (s_valid) begin
                            m_code  <= lo_load;
                            hi_code <= hi_enc;
                            m_last  <= 1'b0;
                            state   <= SEND_LO;
                        end else begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamm_enc_stream.sv
// tb/tb_hamm_enc_stream.sv - self-checking bench for hamm_enc_stream against a positional Hamming model
module tb_hamm_enc_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        parity_type = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [6:0]  m_code;
    logic        m_last;
    logic [15:0] cw_count;
`ifdef HAMM_ENC_ERR_INJ_EN
    logic        err_inj = 1'b0;
    logic [2:0]  err_pos = 3'd0;
`endif

    hamm_enc_stream dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .parity_type(parity_type),
        .m_valid(m_valid), .m_ready(m_ready), .m_code(m_code), .m_last(m_last),
        .cw_count(cw_count)
`ifdef HAMM_ENC_ERR_INJ_EN
        , .err_inj(err_inj), .err_pos(err_pos)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic last; logic [6:0] code; } exp_t;
    typedef struct { int cyc; logic last; logic [6:0] code; } log_t;

    exp_t        expq[$];
    log_t        xlog[$];
    logic [15:0] exp_count = 16'd0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Model works on codeword positions 1..7: data at 3,5,6,7; check bit 2^k covers positions with bit k set.
    function automatic logic [6:0] model_enc(logic [3:0] nib, logic odd, logic [2:0] flip);
        logic [7:0] cw;
        int dpos[4] = '{3, 5, 6, 7};
        logic par;
        cw = '0;
        for (int i = 0; i < 4; i++) cw[dpos[i]] = nib[i];
        for (int k = 0; k < 3; k++) begin
            par = odd;
            for (int p = 1; p < 8; p++)
                if (p[k] && p != (1 << k)) par = par ^ cw[p];
            cw[1 << k] = par;
        end
        if (flip != 3'd0) cw[flip] = ~cw[flip];
        return cw[7:1];
    endfunction

    always @(negedge clk) begin
        logic [2:0] flip;
        cyc++;
        if (!rst_n) begin
            expq.delete();
            exp_count = 16'd0;
            check("rst_m_valid", m_valid, 0);
            check("rst_cw_count", cw_count, 0);
        end else begin
            check("m_valid", m_valid, expq.size() != 0);
            check("s_ready", s_ready, expq.size() == 0 || (expq.size() == 1 && m_ready));
            check("cw_count", cw_count, exp_count);
            if (m_valid && expq.size() != 0) begin
                check("m_code", m_code, expq[0].code);
                check("m_last", m_last, expq[0].last);
            end
            if (m_valid && m_ready) begin
                xlog.push_back('{cyc, m_last, m_code});
                if (expq.size() != 0) void'(expq.pop_front());
                exp_count = exp_count + 16'd1;
            end
            if (s_valid && s_ready) begin
                flip = 3'd0;
`ifdef HAMM_ENC_ERR_INJ_EN
                if (err_inj) flip = err_pos;
`endif
                expq.push_back('{1'b0, model_enc(s_data[3:0], parity_type, flip)});
                expq.push_back('{1'b1, model_enc(s_data[7:4], parity_type, 3'd0)});
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic p);
        int n = 0;
        s_data = d; parity_type = p; s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data = 8'($urandom);
        parity_type = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (m_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", m_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [6:0] held;
        logic [15:0] cnt0;
        int bubbles;

        // Pin the model to hand-derived codewords.
        check("model_5_even", model_enc(4'h5, 1'b0, 3'd0), 7'b0101101);
        check("model_B_even", model_enc(4'hB, 1'b0, 3'd0), 7'b1010101);
        check("model_B_odd",  model_enc(4'hB, 1'b1, 3'd0), 7'b1011110);
        check("model_0_odd",  model_enc(4'h0, 1'b1, 3'd0), 7'b0001011);

        repeat (3) @(posedge clk);
        #1;
        check("reset_m_code", m_code, 0);
        check("reset_m_last", m_last, 0);
        check("reset_s_ready", s_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_s_ready", s_ready, 1);

        xlog.delete();
        send_byte(8'hB5, 1'b0);
        wait_idle();
        check("b5_count", xlog.size(), 2);
        if (xlog.size() >= 2) begin
            check("b5_lo_code", xlog[0].code, 7'b0101101);
            check("b5_lo_last", xlog[0].last, 0);
            check("b5_hi_code", xlog[1].code, 7'b1010101);
            check("b5_hi_last", xlog[1].last, 1);
        end
        check("b5_cw_count", cw_count, 2);

        xlog.delete();
        send_byte(8'h0B, 1'b1);
        wait_idle();
        check("0b_count", xlog.size(), 2);
        if (xlog.size() >= 2) begin
            check("0b_lo_code", xlog[0].code, 7'b1011110);
            check("0b_hi_code", xlog[1].code, 7'b0001011);
        end

        xlog.delete();
        send_byte(8'h12, 1'b0);
        send_byte(8'hA7, 1'b1);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_idle();
        check("b2b_count", xlog.size(), 8);
        bubbles = 0;
        for (int i = 1; i < xlog.size(); i++)
            if (xlog[i].cyc != xlog[i-1].cyc + 1) bubbles++;
        check("b2b_bubbles", bubbles, 0);
        check("b2b_cw_count", cw_count, 12);

        m_ready = 1'b0;
        send_byte(8'h3C, 1'b0);
        held = m_code;
        cnt0 = cw_count;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = 8'($urandom);
            @(negedge clk);
            check("bp_code_stable", m_code, held);
            check("bp_s_ready", s_ready, 0);
            check("bp_count_hold", cw_count, cnt0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_idle();

        m_ready = 1'b0;
        send_byte(8'h96, 1'b1);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("mid_in_send_hi", m_last, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_cw_count", cw_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_ready = 1'b1;
        xlog.delete();
        repeat (5) @(posedge clk);
        #1;
        check("mid_no_residual", xlog.size(), 0);

`ifdef HAMM_ENC_ERR_INJ_EN
        begin
            logic [7:0] cw;
            logic [2:0] syn;
            xlog.delete();
            err_inj = 1'b1; err_pos = 3'd5;
            send_byte(8'hB5, 1'b0);
            err_inj = 1'b0; err_pos = 3'd0;
            wait_idle();
            check("inj_count", xlog.size(), 2);
            if (xlog.size() >= 2) begin
                check("inj_lo_code", xlog[0].code, 7'b0111101);
                cw = {xlog[0].code, 1'b0};
                syn = 3'd0;
                for (int p = 1; p < 8; p++) if (cw[p]) syn = syn ^ 3'(p);
                check("inj_syndrome", syn, 5);
                if (syn != 3'd0) cw[syn] = ~cw[syn];
                check("inj_restored", {cw[7], cw[6], cw[5], cw[3]}, 4'h5);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
